// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: one req/ack memory bus shared by the fetch and data ports, data port first.
// Define ARB_TIMEOUT_EN to abort a BUSY transaction after TIMEOUT unacked cycles (err_o pulse).
module mem_bus_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_ce_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_data_o,
  output logic              if_stall_o,
  input  logic              dm_ce_i,
  input  logic              dm_we_i,
  input  logic [3:0]        dm_sel_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              dm_stall_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [3:0]        bus_sel_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic [DATA_W-1:0] bus_rdata_i,
  input  logic              bus_ack_i,
  output logic              err_o
);
  typedef enum logic [2:0] {IDLE, DM_BUSY, IF_BUSY, DM_DONE, IF_DONE} state_t;
  state_t state, state_nx;
  logic busy, done, tmo, grant;
  assign busy  = (state == DM_BUSY) || (state == IF_BUSY);
  assign grant = (state == IDLE) && (dm_ce_i || if_ce_i);
`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT - 1);
  logic [CW-1:0] cnt;
  assign tmo = busy && !bus_ack_i && (cnt == TMAX);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt   <= '0;
      err_o <= 1'b0;
    end else begin
      cnt   <= busy ? cnt + 1'b1 : '0;
      err_o <= tmo;
    end
`else
  assign tmo   = 1'b0;
  assign err_o = 1'b0;
`endif
  // an ack in the timeout cycle wins because tmo requires !bus_ack_i
  assign done = busy && (bus_ack_i || tmo);
  assign if_stall_o = if_ce_i && (state != IF_DONE);
  assign dm_stall_o = dm_ce_i && (state != DM_DONE);
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  always_comb begin
    state_nx = IDLE;
    case (state)
      IDLE:    state_nx = dm_ce_i ? DM_BUSY : if_ce_i ? IF_BUSY : IDLE;
      DM_BUSY: state_nx = !done ? DM_BUSY : dm_ce_i ? DM_DONE : IDLE;
      IF_BUSY: state_nx = !done ? IF_BUSY : if_ce_i ? IF_DONE : IDLE;
      default: state_nx = IDLE;
    endcase
  end
  // result regs only load when the port is still waiting, so a dropped request leaves them untouched
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_sel_o   <= '0;
      bus_addr_o  <= '0;
      bus_wdata_o <= '0;
      if_data_o   <= '0;
      dm_rdata_o  <= '0;
    end else begin
      if (grant) begin
        bus_req_o   <= 1'b1;
        bus_we_o    <= dm_ce_i && dm_we_i;
        bus_sel_o   <= dm_ce_i ? dm_sel_i : 4'hF;
        bus_addr_o  <= dm_ce_i ? dm_addr_i : if_addr_i;
        bus_wdata_o <= dm_ce_i ? dm_wdata_i : '0;
      end
      if (done) bus_req_o <= 1'b0;
      if (done && state == DM_BUSY && dm_ce_i) dm_rdata_o <= tmo ? '0 : bus_rdata_i;
      if (done && state == IF_BUSY && if_ce_i) if_data_o <= tmo ? '0 : bus_rdata_i;
    end
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one external memory bus (single outstanding req/ack transaction) between the instruction-fetch port (pc_reg/if_id side) and the data port (MEM stage side).
- Replaces the separate ROM/RAM interfaces at the core boundary.
- Produces per-port stall requests that ctrl merges into the pipeline stall vector.
- Data port has fixed priority over fetch, because the data access belongs to the older instruction.

Parameters:
ADDR_W, 32, address width of both ports and the bus
DATA_W, 32, data width
TIMEOUT, 16, cycles to wait for bus_ack_i before abort (used only with ARB_TIMEOUT_EN)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
if_ce_i  in  1  fetch request valid (held by pipeline until serviced)
if_addr_i  in  ADDR_W  fetch address
if_data_o  out  DATA_W  fetched instruction, valid while if_stall_o=0 and if_ce_i=1
if_stall_o  out  1  stall request, fetch port
dm_ce_i  in  1  data access valid
dm_we_i  in  1  1=write, 0=read
dm_sel_i  in  4  byte lane enables
dm_addr_i  in  ADDR_W  data address
dm_wdata_i  in  DATA_W  store data
dm_rdata_o  out  DATA_W  load data, valid while dm_stall_o=0 and dm_ce_i=1
dm_stall_o  out  1  stall request, data port
bus_req_o  out  1  bus transaction request (registered)
bus_we_o  out  1  bus write enable (registered)
bus_sel_o  out  4  byte enables (registered; 4'b1111 for fetch)
bus_addr_o  out  ADDR_W  bus address (registered)
bus_wdata_o  out  DATA_W  bus write data (registered)
bus_rdata_i  in  DATA_W  bus read data, sampled when bus_ack_i=1
bus_ack_i  in  1  transaction complete
err_o  out  1  one-cycle timeout pulse (ARB_TIMEOUT_EN only)

Behaviour:
- Reset (rst=0, async): state=IDLE; bus_req_o, bus_we_o, err_o = 0; bus_sel_o, bus_addr_o, bus_wdata_o, if_data_o, dm_rdata_o = 0; hold regs cleared. A mid-transaction reset drops bus_req_o immediately; any late ack is ignored.
- States: IDLE, DM_BUSY, IF_BUSY, DM_DONE, IF_DONE.
- IDLE:
  - dm_ce_i=1: latch dm fields onto the bus regs, go to DM_BUSY.
  - Else if_ce_i=1: latch if_addr_i, we=0, sel=4'b1111, go to IF_BUSY.
  - Else stay. bus_req_o=1 from the cycle after the grant.
- x_BUSY:
  - bus_req_o held 1 with stable fields.
  - On bus_ack_i=1: capture bus_rdata_i into that port's hold reg, drop bus_req_o.
  - Next state is x_DONE if the port's ce is still 1, else IDLE (result discarded).
- x_DONE: lasts exactly one cycle; that port's stall=0 and data output=hold reg. Always returns to IDLE; no grant is issued in a DONE cycle.
- Stall rules:
  - if_stall_o = if_ce_i & (state != IF_DONE).
  - dm_stall_o = dm_ce_i & (state != DM_DONE).
  - Both are combinational on ce and state.
- Minimum latency (zero-wait slave, ack in first BUSY cycle): stall high on request cycle and BUSY cycle, low on the 3rd cycle.
- Simultaneous requests in IDLE: data wins; fetch stays stalled.
- Fetch done while dm stalled: the whole pipeline stalls, the fetched word is not consumed, and the same address is refetched later. This is correct, not an error.
- Writes complete on ack; dm_rdata_o in DM_DONE for a write is don't-care (hold reg still updated).
- bus_ack_i while IDLE/DONE: ignored.
- Output data regs hold their last value outside DONE.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on BUSY entry and increments each BUSY cycle without ack.
  - When it reaches TIMEOUT: drop bus_req_o, load the port hold reg with 0, pulse err_o for 1 cycle, go to x_DONE (or IDLE if ce dropped).
  - An ack in the same cycle as the timeout wins, with no err_o pulse.
- Undefined: no counter; BUSY waits indefinitely; err_o tied 0.

Test Plan:
- Reset values: rst=0 mid-DM_BUSY with bus_req_o=1 -> bus_req_o=0 the same cycle. After release, state=IDLE and all outputs 0.
- Fetch, zero-wait slave: if_ce_i=1, addr=0x100, slave acks in the first req cycle with 0x3C011234 -> if_stall_o = 1,1,0; if_data_o=0x3C011234 in cycle 3; bus_sel_o=4'hF.
- Priority: if_ce_i=1 and dm_ce_i=1 (lw, addr 0x80) in the same IDLE cycle -> bus_addr_o=0x80 first. Fetch is issued only after DM_DONE; if_stall_o stays 1 throughout.
- Store with 3-cycle ack delay: dm_we_i=1, sel=4'b0011, wdata=0xAABBCCDD -> bus fields stable for all req cycles; dm_stall_o falls exactly one cycle after ack.
- Drop during BUSY: if_ce_i falls while IF_BUSY; ack arrives -> state goes to IDLE with no IF_DONE; if_data_o unchanged.
- Timeout (ARB_TIMEOUT_EN, TIMEOUT=4): no ack on a dm read -> bus_req_o drops after 4 cycles; err_o=1 for one cycle; dm_rdata_o=0 with dm_stall_o=0 in DM_DONE.
